// File: rtl/conv_result_writer.sv
// Output-side writer for the strided convolution stream: tags each window result
// with its linear output-map address, buffers it and writes it out over valid/ready.
module conv_result_writer #(
  parameter int FILTER_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int STRIDE      = 1,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  localparam int OUT_SIZE   = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1,
  localparam int OUT_COUNT  = OUT_SIZE * OUT_SIZE,
  localparam int ADDR_W     = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  stall,
  output logic                  mem_wr_en,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_COUNT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt;       // FIFO entries plus the output register
  logic [ADDR_W-1:0] wr_idx;
  entry_t            out_q;
  logic              out_vld;

  logic cap, pop, full, accept, load_out, fifo_nonempty, bypass, push, fifo_rd;

  always_comb begin
    cap           = clk_en & in_valid;
    pop           = out_vld & mem_ready;
    full          = (cnt == CNT_W'(FIFO_DEPTH));
    accept        = cap & (~full | pop);
    load_out      = ~out_vld | pop;
    fifo_nonempty = (cnt > CNT_W'(out_vld));
    bypass        = accept & load_out & ~fifo_nonempty;
    push          = accept & ~bypass;
    fifo_rd       = load_out & fifo_nonempty;
  end

  // Storage is capped at FIFO_DEPTH total, so the array never holds more than
  // FIFO_DEPTH-1 entries and a same-edge read and write never collide.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: wr_idx, data: in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      wr_idx     <= '0;
      out_q      <= '0;
      out_vld    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Address advances on every capture, dropped or not, to keep the map aligned
      if (cap) wr_idx <= (wr_idx == LAST_ADDR) ? '0 : wr_idx + ADDR_W'(1);
      if (cap & ~accept) overflow <= 1'b1;
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
      if (fifo_rd) begin
        out_q   <= fifo_mem[rd_ptr];
        out_vld <= 1'b1;
      end else if (bypass) begin
        out_q   <= '{addr: wr_idx, data: in_data};
        out_vld <= 1'b1;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
      frame_done <= pop && (out_q.addr == LAST_ADDR);
    end
  end

  always_comb begin
    stall       = (cnt >= CNT_W'(FIFO_DEPTH - 2));
    mem_wr_en   = out_vld;
    mem_addr    = out_q.addr;
    mem_wr_data = out_q.data;
    busy        = fifo_nonempty | out_vld | (wr_idx != '0);
  end
endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench: a stride-1 and a stride-2 writer share one stimulus stream;
// each has its own expected-write queue, address counter and occupancy model.
module tb_conv_result_writer;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, in_valid, mem_ready;
  logic [15:0] in_data;

  logic        stall_a, we_a, fd_a, ovf_a, busy_a;
  logic [5:0]  addr_a;
  logic [15:0] wd_a;
  logic        stall_b, we_b, fd_b, ovf_b, busy_b;
  logic [3:0]  addr_b;
  logic [15:0] wd_b;

  conv_result_writer u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .in_data(in_data),
    .stall(stall_a), .mem_wr_en(we_a), .mem_ready(mem_ready), .mem_addr(addr_a),
    .mem_wr_data(wd_a), .frame_done(fd_a), .overflow(ovf_a), .busy(busy_a));

  conv_result_writer #(.STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .in_data(in_data),
    .stall(stall_b), .mem_wr_en(we_b), .mem_ready(mem_ready), .mem_addr(addr_b),
    .mem_wr_data(wd_b), .frame_done(fd_b), .overflow(ovf_b), .busy(busy_b));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  localparam int DEPTH = 8;
  int lastv [2] = '{35, 8};
  int q_a [2][$];
  int q_d [2][$];
  int widx [2];
  bit ovf_m [2];
  bit fd_exp [2];

  // Check outputs against the model, then advance the model across the next edge
  always @(negedge clk) begin
    int ga [2], gd [2], gwe [2], gfd [2], gst [2], gov [2], gbz [2];
    ga  = '{int'(addr_a), int'(addr_b)};
    gd  = '{int'(wd_a), int'(wd_b)};
    gwe = '{int'(we_a), int'(we_b)};
    gfd = '{int'(fd_a), int'(fd_b)};
    gst = '{int'(stall_a), int'(stall_b)};
    gov = '{int'(ovf_a), int'(ovf_b)};
    gbz = '{int'(busy_a), int'(busy_b)};
    for (int m = 0; m < 2; m++) begin
      string p;
      int sz;
      bit pop;
      p = (m == 0) ? "s1." : "s2.";
      if (!rst_n) begin
        q_a[m].delete();
        q_d[m].delete();
        widx[m] = 0; ovf_m[m] = 0; fd_exp[m] = 0;
        chk({p, "rst_wr_en"}, gwe[m], 0);
        chk({p, "rst_busy"}, gbz[m], 0);
      end else begin
        sz = q_a[m].size();
        chk({p, "wr_en"}, gwe[m], int'(sz > 0));
        if (sz > 0) begin
          chk({p, "addr"}, ga[m], q_a[m][0]);
          chk({p, "data"}, gd[m], q_d[m][0]);
        end
        chk({p, "frame_done"}, gfd[m], int'(fd_exp[m]));
        chk({p, "stall"}, gst[m], int'(sz >= DEPTH - 2));
        chk({p, "overflow"}, gov[m], int'(ovf_m[m]));
        chk({p, "busy"}, gbz[m], int'(sz > 0 || widx[m] != 0));
        pop = (sz > 0) && mem_ready;
        fd_exp[m] = pop && (q_a[m][0] == lastv[m]);
        if (pop) begin
          void'(q_a[m].pop_front());
          void'(q_d[m].pop_front());
        end
        if (clk_en && in_valid) begin
          if (sz == DEPTH && !pop) ovf_m[m] = 1;
          else begin
            q_a[m].push_back(widx[m]);
            q_d[m].push_back(int'(in_data));
          end
          widx[m] = (widx[m] == lastv[m]) ? 0 : widx[m] + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_now();
    chk("rst_stall", stall_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_data", wd_a, 0);
    chk("rst_fd", fd_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_busy_now", busy_a, 0);
    chk("rst_we_s2", we_b, 0);
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk_reset_now();
    cyc(); cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    mem_ready = 1;
    while ((we_a || we_b) && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    cyc();
  endtask

  initial begin
    rst_n = 0; clk_en = 0; in_valid = 0; in_data = 0; mem_ready = 0;
    repeat (3) cyc();
    rst_n = 1;
    cyc();

    // Basic map; the stride-2 instance sees four 9-entry frames back to back
    mem_ready = 1; clk_en = 1;
    for (int i = 0; i < 36; i++) begin
      in_valid = 1; in_data = 16'(i);
      cyc();
    end
    in_valid = 0;
    repeat (4) cyc();

    // Backpressure while honoring stall
    mem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = !stall_a; in_data = 16'(100 + i);
      cyc();
    end
    drain();

    // Overflow: ignore stall, 10 captures into 8 entries
    do_reset();
    mem_ready = 0; clk_en = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = 16'(200 + i);
      cyc();
    end
    in_valid = 0;
    repeat (3) cyc();
    mem_ready = 1; in_valid = 1; in_data = 16'd300;
    cyc();
    drain();

    // clk_en gating while drain continues
    mem_ready = 0; clk_en = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 16'(400 + i);
      cyc();
    end
    mem_ready = 1; clk_en = 0; in_valid = 1; in_data = 16'hdead;
    repeat (5) cyc();
    clk_en = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = 16'(410 + i);
      cyc();
    end
    drain();

    // Reset mid-frame
    do_reset();
    mem_ready = 1; clk_en = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_data = 16'(500 + i);
      cyc();
    end
    do_reset();
    clk_en = 1; in_valid = 1; in_data = 16'd600;
    cyc();
    drain();

    // Random traffic honoring stall
    for (int i = 0; i < 400; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      clk_en    = ($urandom_range(0, 7) != 0);
      in_valid  = !stall_a && ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      cyc();
    end
    drain();
    clk_en = 0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Write-side companion to the line buffer controller. It takes the strided window results that the convolution datapath emits, one per window-valid cycle. It tags each result with its linear output-map address, buffers results in a small FIFO, and writes them to the output feature-map memory over a valid/ready port. Backpressure from the memory is returned to the stream pipeline as a `stall` flag, which gates the shared `clk_en`. A `frame_done` pulse marks the final write of each output map.

## Interface
- `FILTER_SIZE`, default 3: window edge length.
- `IMAGE_SIZE`, default 8: input image edge length.
- `STRIDE`, default 1: window stride.
- `DATA_WIDTH`, default 16: result word width.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two and ≥ 4.
- Derived: OUT_SIZE = (IMAGE_SIZE-FILTER_SIZE)/STRIDE + 1, using integer division.
- Derived: OUT_COUNT = OUT_SIZE*OUT_SIZE.
- Derived: ADDR_W = `LOG2(OUT_COUNT)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  stream-pipeline enable; qualifies `in_valid` only.
- `in_valid`  in  1  a result is present this cycle.
- `in_data`  in  DATA_WIDTH  result word.
- `stall`  out  1  request to deassert upstream `clk_en`.
- `mem_wr_en`  out  1  write request (valid).
- `mem_ready`  in  1  memory accepts the write this cycle.
- `mem_addr`  out  ADDR_W  linear address, out_y*OUT_SIZE + out_x.
- `mem_wr_data`  out  DATA_WIDTH  write data.
- `frame_done`  out  1  one-cycle pulse after the last write of a map.
- `overflow`  out  1  sticky flag: a result was dropped.
- `busy`  out  1  any result is accepted but not yet written.

## Operation
- **Capture.** A result is captured on a rising edge with `clk_en && in_valid`. Without `clk_en`, `in_valid` is ignored.
- **Address tag.** Each captured result is paired with the current value of the address counter `wr_idx`. `wr_idx` counts 0 .. OUT_COUNT-1, then wraps to 0. It is incremented, never multiplied.
- **Storage.** Each {addr, data} pair is pushed into the FIFO. The FIFO feeds an output register that drives `mem_*`.
- **Fall-through.** If the output register is empty, or is being drained this cycle, and the FIFO is empty, a captured pair loads the output register directly.
- **Drain.** The drain side runs every cycle, independent of `clk_en`. A transfer occurs on an edge where `mem_wr_en && mem_ready`.
- **Output stability.** While `mem_wr_en=1 && mem_ready=0`, `mem_addr` and `mem_wr_data` hold stable.
- **Stall.** `stall` = stored entries ≥ FIFO_DEPTH-2. Stored entries count the FIFO plus the output register. The two-entry margin covers the registered upstream valid.
- **Overflow.** A capture while all storage is full and nothing drains that edge is dropped:
  - `wr_idx` still advances, so the map stays aligned;
  - `overflow` is set and held until reset.
- **Frame completion.** `frame_done` pulses for one cycle on the edge after the transfer whose address is OUT_COUNT-1.
- **Back-to-back frames.** Results of the next frame may be captured before the previous frame drains. They restart at address 0, and order is preserved.
- **Busy.** `busy` = (FIFO non-empty) | `mem_wr_en` | (`wr_idx` ≠ 0).

## Timing
- **Reset values.** Asynchronous reset (`rst_n`=0) clears every output:
  - `stall`, `mem_wr_en`, `mem_addr`, `mem_wr_data`, `frame_done`, `overflow` and `busy` are all 0;
  - `wr_idx` and the FIFO pointers are 0;
  - contents in flight are discarded.
- **Reset mid-operation.** Reset mid-frame abandons the partial map; no `frame_done` is issued for it.
- **Latency.** The minimum latency is one cycle: a capture at edge N with empty storage gives `mem_wr_en=1` after edge N, carrying that result.
- **Throughput.** With `mem_ready` held high, sustained throughput is one result per cycle.
- **Simultaneous push and pop at full.** Both are legal and no drop occurs.
- **Simultaneous push and pop at empty.** The data falls through with no bubble.
- **Frame-done overlap.** `frame_done` may coincide with `mem_wr_en=1` for address 0 of the next frame.
- **Address wrap.** Capture of address OUT_COUNT-1 is followed by address 0 on the next capture.

## Test plan
- **Basic map.** IMAGE_SIZE=8, FILTER_SIZE=3, STRIDE=1 (OUT_COUNT=36); `mem_ready`=1; 36 captures with `in_data`=i.
  - Required: 36 writes, `mem_addr`=i, `mem_wr_data`=i, each one cycle after its capture.
  - Required: `frame_done` on the edge after address 35; `busy`=0 afterwards.
- **Strided map.** STRIDE=2 (OUT_SIZE=3).
  - Required: addresses run 0..8, then `frame_done`, then the next frame starts at 0.
- **Backpressure.** FIFO_DEPTH=8; `mem_ready`=0 for 20 cycles while capturing continuously.
  - Required: `stall`=1 once 6 entries are stored; addr/data stay stable while blocked.
  - Required: after release, in-order writes with no duplicates.
- **Overflow.** Ignore `stall` and capture 10 results with `mem_ready`=0, FIFO_DEPTH=8.
  - Required: the 9th and 10th results are dropped; `overflow`=1 and sticky.
  - Required: the next capture uses address 10.
- **clk_en gating.** `in_valid`=1 with `clk_en`=0 for 5 cycles.
  - Required: no capture and `wr_idx` unchanged.
  - Required: drain of earlier entries continues during those cycles.
- **Reset mid-frame.** Pulse `rst_n` low after 20 captures of a 36-entry frame.
  - Required: all outputs 0 immediately.
  - Required: the next capture writes address 0, and no `frame_done` is issued for the abandoned frame.
